// File: rtl/sram_1p_march_bist.sv
// rtl/sram_1p_march_bist.sv - March C- BIST controller for the single-port bit-maskable SRAM; first-failure diagnostics built only with SRAM_1P_BIST_DIAG_EN
module sram_1p_march_bist #(
   parameter int P_DATA_WIDTH = 24,
   parameter int P_ADDR_WIDTH = 14
) (
   input  logic                    A_CLK,
   input  logic                    A_RST,
   input  logic                    A_START,
   output logic                    A_BUSY,
   output logic                    A_DONE,
   output logic                    A_FAIL,
   output logic [P_ADDR_WIDTH-1:0] A_FAIL_ADDR,
   output logic [2:0]              A_FAIL_ELEM,
   output logic [P_DATA_WIDTH-1:0] A_FAIL_BITS,
   input  logic [P_DATA_WIDTH-1:0] A_BIST_DOUT,
   output logic                    A_BIST_EN,
   output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
   output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
   output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
   output logic                    A_BIST_MEN,
   output logic                    A_BIST_WEN,
   output logic                    A_BIST_REN,
   output logic                    A_BIST_CLK
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   localparam logic [P_ADDR_WIDTH-1:0] ADDR_ZERO = '0;
   localparam logic [P_ADDR_WIDTH-1:0] ADDR_ONE  = {{(P_ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [P_ADDR_WIDTH-1:0] ADDR_LAST = {P_ADDR_WIDTH{1'b1}};

   state_t                  state_q, state_d;
   logic [2:0]              elem_q, elem_d;
   logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                    phase_q, phase_d;   // 0: read slot, 1: write slot of a r/w element
   logic                    pend_q, pend_d;     // a read was executed last edge, compare now
   logic [P_DATA_WIDTH-1:0] exp_q, exp_d;
   logic                    done_q, done_d;
   logic                    fail_q, fail_d;

   logic                    elem_down, elem_has_rd, elem_has_wr, rd_ones, wr_ones;
   logic                    op_rd, op_wr, addr_done, last_addr, mismatch, start_ok;
   logic [P_DATA_WIDTH-1:0] miss_bits;

   // Decode the current element and the op presented this cycle
   always_comb begin
      elem_down   = (elem_q == 3'd3) || (elem_q == 3'd4);
      elem_has_rd = (elem_q != 3'd0);
      elem_has_wr = (elem_q != 3'd5);
      rd_ones     = (elem_q == 3'd2) || (elem_q == 3'd4);
      wr_ones     = (elem_q == 3'd1) || (elem_q == 3'd3);
      op_rd       = (state_q == S_RUN) && elem_has_rd && !phase_q;
      op_wr       = (state_q == S_RUN) && elem_has_wr && (phase_q || !elem_has_rd);
      addr_done   = op_wr || (op_rd && !elem_has_wr);
      last_addr   = elem_down ? (addr_q == ADDR_ZERO) : (addr_q == ADDR_LAST);
      miss_bits   = A_BIST_DOUT ^ exp_q;
      mismatch    = pend_q && (miss_bits != '0);
      start_ok    = A_START && ((state_q == S_IDLE) || (state_q == S_DONE));
   end

   // Next-state: walk slots, addresses and elements; track done/fail
   always_comb begin
      state_d = state_q;
      elem_d  = elem_q;
      addr_d  = addr_q;
      phase_d = phase_q;
      pend_d  = op_rd;
      exp_d   = rd_ones ? '1 : '0;
      done_d  = done_q;
      fail_d  = fail_q | mismatch;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_ok) begin
               state_d = S_RUN;
               elem_d  = 3'd0;
               addr_d  = ADDR_ZERO;
               phase_d = 1'b0;
               done_d  = 1'b0;
               fail_d  = 1'b0;
            end
         end
         S_RUN: begin
            if (op_rd && elem_has_wr) begin
               phase_d = 1'b1;
            end else if (addr_done) begin
               phase_d = 1'b0;
               if (!last_addr) begin
                  addr_d = elem_down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
               end else if (elem_q == 3'd5) begin
                  state_d = S_DRAIN;
               end else begin
                  elem_d = elem_q + 3'd1;
                  addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_LAST : ADDR_ZERO;
               end
            end
         end
         S_DRAIN: begin
            state_d = S_DONE;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge A_CLK) begin
      if (A_RST) begin
         state_q <= S_IDLE;
         elem_q  <= 3'd0;
         addr_q  <= ADDR_ZERO;
         phase_q <= 1'b0;
         pend_q  <= 1'b0;
         exp_q   <= '0;
         done_q  <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         elem_q  <= elem_d;
         addr_q  <= addr_d;
         phase_q <= phase_d;
         pend_q  <= pend_d;
         exp_q   <= exp_d;
         done_q  <= done_d;
         fail_q  <= fail_d;
      end
   end

`ifdef SRAM_1P_BIST_DIAG_EN
   logic [P_ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d, fail_addr_q, fail_addr_d;
   logic [2:0]              pend_elem_q, pend_elem_d, fail_elem_q, fail_elem_d;
   logic [P_DATA_WIDTH-1:0] fail_bits_q, fail_bits_d;

   // Carry the read's address/element alongside it; latch only the first mismatch
   always_comb begin
      pend_addr_d = addr_q;
      pend_elem_d = elem_q;
      fail_addr_d = fail_addr_q;
      fail_elem_d = fail_elem_q;
      fail_bits_d = fail_bits_q;
      if (start_ok) begin
         fail_addr_d = '0;
         fail_elem_d = '0;
         fail_bits_d = '0;
      end else if (mismatch && !fail_q) begin
         fail_addr_d = pend_addr_q;
         fail_elem_d = pend_elem_q;
         fail_bits_d = miss_bits;
      end
   end

   // Diagnostic registers
   always_ff @(posedge A_CLK) begin
      if (A_RST) begin
         pend_addr_q <= '0;
         pend_elem_q <= '0;
         fail_addr_q <= '0;
         fail_elem_q <= '0;
         fail_bits_q <= '0;
      end else begin
         pend_addr_q <= pend_addr_d;
         pend_elem_q <= pend_elem_d;
         fail_addr_q <= fail_addr_d;
         fail_elem_q <= fail_elem_d;
         fail_bits_q <= fail_bits_d;
      end
   end

   assign A_FAIL_ADDR = fail_addr_q;
   assign A_FAIL_ELEM = fail_elem_q;
   assign A_FAIL_BITS = fail_bits_q;
`else
   assign A_FAIL_ADDR = '0;
   assign A_FAIL_ELEM = '0;
   assign A_FAIL_BITS = '0;
`endif

   assign A_BUSY      = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign A_DONE      = done_q;
   assign A_FAIL      = fail_q;
   assign A_BIST_EN   = A_BUSY;
   assign A_BIST_MEN  = op_rd || op_wr;
   assign A_BIST_WEN  = op_wr;
   assign A_BIST_REN  = op_rd;
   assign A_BIST_ADDR = (op_rd || op_wr) ? addr_q : ADDR_ZERO;
   assign A_BIST_DIN  = (op_wr && wr_ones) ? '1 : '0;
   assign A_BIST_BM   = op_wr ? '1 : '0;
   assign A_BIST_CLK  = A_CLK;

endmodule

// File: tb/tb_sram_1p_march_bist.sv
// tb/tb_sram_1p_march_bist.sv - scoreboard bench for sram_1p_march_bist with a behavioural SRAM and stuck-at fault
module tb_sram_1p_march_bist;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int N  = 16;
   localparam int RUN_BUSY = 10 * N + 1;

   logic          clk = 1'b0;
   logic          rst, start;
   logic          busy, done, fail;
   logic [AW-1:0] fail_addr;
   logic [2:0]    fail_elem;
   logic [DW-1:0] fail_bits;
   logic [DW-1:0] dout;
   logic          en, men, wen, ren, bclk;
   logic [AW-1:0] addr;
   logic [DW-1:0] din, bm;
   logic          stuck_en;

   always #5 clk = ~clk;

   sram_1p_march_bist #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW)) dut (
      .A_CLK(clk), .A_RST(rst), .A_START(start),
      .A_BUSY(busy), .A_DONE(done), .A_FAIL(fail),
      .A_FAIL_ADDR(fail_addr), .A_FAIL_ELEM(fail_elem), .A_FAIL_BITS(fail_bits),
      .A_BIST_DOUT(dout), .A_BIST_EN(en), .A_BIST_ADDR(addr), .A_BIST_DIN(din),
      .A_BIST_BM(bm), .A_BIST_MEN(men), .A_BIST_WEN(wen), .A_BIST_REN(ren),
      .A_BIST_CLK(bclk)
   );

   // behavioural SRAM core; bit 3 of address 5 reads back stuck at 1 when enabled
   logic [DW-1:0] mem [N];
   always @(posedge bclk) begin
      if (men) begin
         if (wen) mem[addr] <= (mem[addr] & ~bm) | (din & bm);
         if (ren) dout <= mem[addr] | ((stuck_en && addr == 4'd5) ? 8'h08 : 8'h00);
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event occurred when none was expected or bound expired", name);
   endtask

   // scoreboard queues: ops are {wen, ren, addr, din, bm}
   typedef struct {
      int            busy;
      logic          fail;
      logic [AW-1:0] faddr;
      logic [2:0]    felem;
      logic [DW-1:0] fbits;
   } res_t;

   logic [21:0] ops_q [$];
   res_t        res_q [$];

   task automatic push_run_ops();
      logic [AW-1:0] a;
      logic [DW-1:0] wv;
      for (int e = 0; e < 6; e++) begin
         wv = (e == 1 || e == 3) ? 8'hFF : 8'h00;
         for (int i = 0; i < N; i++) begin
            a = (e == 3 || e == 4) ? AW'(N - 1 - i) : AW'(i);
            if (e != 0) ops_q.push_back({1'b0, 1'b1, a, 8'h00, 8'h00});
            if (e != 5) ops_q.push_back({1'b1, 1'b0, a, wv, 8'hFF});
         end
      end
   endtask

   task automatic push_result(input bit faulty);
      res_t r;
      r.busy  = RUN_BUSY;
      r.fail  = faulty;
      r.faddr = '0;
      r.felem = '0;
      r.fbits = '0;
`ifdef SRAM_1P_BIST_DIAG_EN
      if (faulty) begin
         r.faddr = 4'd5;
         r.felem = 3'd1;
         r.fbits = 8'h08;
      end
`endif
      res_q.push_back(r);
   endtask

   // hand-computed op spot table: index -> {wen, ren, addr, din, bm}
   int          spot_idx [7] = '{0, 15, 16, 17, 80, 96, 159};
   logic [21:0] spot_val [7] = '{
      {1'b1, 1'b0, 4'd0,  8'h00, 8'hFF},
      {1'b1, 1'b0, 4'd15, 8'h00, 8'hFF},
      {1'b0, 1'b1, 4'd0,  8'h00, 8'h00},
      {1'b1, 1'b0, 4'd0,  8'hFF, 8'hFF},
      {1'b0, 1'b1, 4'd15, 8'h00, 8'h00},
      {1'b0, 1'b1, 4'd7,  8'h00, 8'h00},
      {1'b0, 1'b1, 4'd15, 8'h00, 8'h00}};

   logic        done_prev = 1'b0;
   int          busy_cnt  = 0;
   int          op_idx    = 0;
   logic [21:0] op_act, op_exp;
   res_t        r_exp;

   // monitor: pop and compare on every SRAM op and on every DONE rise
   always @(negedge clk) begin
      if (rst) begin
         busy_cnt = 0;
         op_idx   = 0;
      end else begin
         if (busy) busy_cnt++;
         if (men) begin
            op_act = {wen, ren, addr, wen ? din : 8'h00, wen ? bm : 8'h00};
            if (ops_q.size() == 0) fail_now("op_unexpected");
            else begin
               op_exp = ops_q.pop_front();
               check($sformatf("op%0d", op_idx), op_act, op_exp);
            end
            for (int k = 0; k < 7; k++)
               if (spot_idx[k] == op_idx) check($sformatf("spot_op%0d", op_idx), op_act, spot_val[k]);
            op_idx++;
         end
         if (done && !done_prev) begin
            if (res_q.size() == 0) fail_now("done_unexpected");
            else begin
               r_exp = res_q.pop_front();
               check("busy_cycles", busy_cnt, r_exp.busy);
               check("res_fail", fail, r_exp.fail);
               check("res_fail_addr", fail_addr, r_exp.faddr);
               check("res_fail_elem", fail_elem, r_exp.felem);
               check("res_fail_bits", fail_bits, r_exp.fbits);
            end
            busy_cnt = 0;
            op_idx   = 0;
         end
      end
      done_prev = done;
   end

   task automatic do_start(input bit expect_done, input bit faulty);
      push_run_ops();
      if (expect_done) push_result(faulty);
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (!done && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (!done) fail_now("done_timeout");
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      stuck_en = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_fail", fail, 0);
      check("rst_en", en, 0);
      check("rst_men", men, 0);
      check("rst_wen_ren", {wen, ren}, 0);
      check("rst_addr", addr, 0);
      check("rst_din_bm", {din, bm}, 0);
      check("rst_diag", {fail_addr, fail_elem, fail_bits}, 0);
      check("bist_clk_lo", bclk, 0);
      @(posedge clk);
      #1 check("bist_clk_hi", bclk, 1);

      // fault-free run with full sequence check
      do_start(1'b1, 1'b0);
      wait_done(200);

      // start pulse mid-run is ignored
      do_start(1'b1, 1'b0);
      repeat (30) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(200);

      // stuck-at-1 run; start held high into DONE restarts at once
      stuck_en = 1'b1;
      do_start(1'b1, 1'b1);
      repeat (150) @(posedge clk);
      push_run_ops();
      push_result(1'b0);
      #1 start = 1'b1;
      wait_done(200);
      stuck_en = 1'b0;
      check("held_done_seen", done, 1);
      check("held_fail_seen", fail, 1);
      @(negedge clk);
      check("restart_busy", busy, 1);
      check("restart_done_clr", done, 0);
      check("restart_fail_clr", fail, 0);
      check("restart_diag_clr", {fail_addr, fail_elem, fail_bits}, 0);
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(200);

      // reset mid-run after a fault was flagged
      stuck_en = 1'b1;
      do_start(1'b0, 1'b1);
      repeat (50) @(posedge clk);
      #1 check("pre_rst_fail", fail, 1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      ops_q.delete();
      stuck_en = 1'b0;
      @(negedge clk);
      check("midrst_en", en, 0);
      check("midrst_busy", busy, 0);
      check("midrst_fail", fail, 0);
      check("midrst_done", done, 0);
      check("midrst_men", men, 0);
      check("midrst_diag", {fail_addr, fail_elem, fail_bits}, 0);
      do_start(1'b1, 1'b0);
      wait_done(200);

      repeat (3) @(negedge clk);
      check("ops_left", ops_q.size(), 0);
      check("results_left", res_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
